// File: rtl/ahb_if_pkg.sv
// rtl/ahb_if_pkg.sv - AHB-Lite encodings and bridge FSM state type
package ahb_if_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_DONE   = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } bridge_state_e;

endpackage

// File: rtl/ahb_strobe_gen.sv
// rtl/ahb_strobe_gen.sv - byte-lane write enables and alignment check for one AHB transfer
module ahb_strobe_gen
    import ahb_if_pkg::*;
(
    input  logic [2:0]  hsize,
    input  logic [1:0]  addr,
    output logic [31:0] biten,
    output logic        misaligned
);

    // Sizes wider than a word are reported through the same flag as misalignment.
    always_comb begin
        biten      = '0;
        misaligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: biten = 32'h0000_00FF << {addr, 3'b000};
            HSIZE_HALF: begin
                biten      = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                misaligned = addr[0];
            end
            HSIZE_WORD: begin
                biten      = '1;
                misaligned = |addr;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_csr_bridge.sv
// rtl/ahb_csr_bridge.sv - AHB-Lite subordinate driving the single-request CSR cpuif
module ahb_csr_bridge
    import ahb_if_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic                      hsel_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic                      hready_i,
    input  logic [DATA_WIDTH-1:0]     hwdata_i,
    output logic                      hreadyout_o,
    output logic                      hresp_o,
    output logic [DATA_WIDTH-1:0]     hrdata_o,
    output logic                      s_cpuif_req,
    output logic                      s_cpuif_req_is_wr,
    output logic [CSR_ADDR_WIDTH-1:0] s_cpuif_addr,
    output logic [DATA_WIDTH-1:0]     s_cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]     s_cpuif_wr_biten,
    input  logic                      s_cpuif_req_stall_wr,
    input  logic                      s_cpuif_req_stall_rd,
    input  logic                      s_cpuif_rd_ack,
    input  logic                      s_cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]     s_cpuif_rd_data,
    input  logic                      s_cpuif_wr_ack,
    input  logic                      s_cpuif_wr_err
);

    bridge_state_e               state_q, state_d;
    logic [CSR_ADDR_WIDTH-3:0]   addr_q, addr_d;
    logic                        hwrite_q, hwrite_d;
    logic [DATA_WIDTH-1:0]       biten_q, biten_d;
    logic [DATA_WIDTH-1:0]       hrdata_q, hrdata_d;

    logic [31:0] strobe;
    logic        misaligned;
    logic        accept;
    logic        range_err;
    logic        stall;
    logic        ack;
    logic        err;

    ahb_strobe_gen u_strobe_gen (
        .hsize      (hsize_i),
        .addr       (haddr_i[1:0]),
        .biten      (strobe),
        .misaligned (misaligned)
    );

    always_comb begin
        accept    = hsel_i & hready_i &
                    ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));
        range_err = |haddr_i[AHB_ADDR_WIDTH-1:CSR_ADDR_WIDTH];
        stall     = hwrite_q ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd;
        ack       = hwrite_q ? s_cpuif_wr_ack       : s_cpuif_rd_ack;
        err       = hwrite_q ? s_cpuif_wr_err       : s_cpuif_rd_err;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hwrite_d    = hwrite_q;
        biten_d     = biten_q;
        hrdata_d    = hrdata_q;
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        s_cpuif_req = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d   = haddr_i[CSR_ADDR_WIDTH-1:2];
                    hwrite_d = hwrite_i;
                    biten_d  = hwrite_i ? strobe : '0;
                    state_d  = (misaligned | range_err) ? ST_ERR1 : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                hreadyout_o = 1'b0;
                s_cpuif_req = 1'b1;
                // An ack is only meaningful once the request has been taken, i.e. not stalled.
                if (!stall && ack) begin
                    if (err) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_DONE;
                        if (!hwrite_q) begin
                            hrdata_d = s_cpuif_rd_data;
                        end
                    end
                end
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            hwrite_q <= 1'b0;
            biten_q  <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            hwrite_q <= hwrite_d;
            biten_q  <= biten_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign hrdata_o          = hrdata_q;
    assign s_cpuif_req_is_wr = hwrite_q;
    assign s_cpuif_addr      = {addr_q, 2'b00};
    assign s_cpuif_wr_data   = hwdata_i;
    assign s_cpuif_wr_biten  = biten_q;

endmodule
